seg_message_scanner: RTL and testbench
======================================

// Module: seg_message_scanner
// PURPOSE
//  Drives an NUM_DIGITS-wide multiplexed 7-segment display with fixed status/error messages ("Err", "CE0", "SEr", ...).
//  Sits between the machine controller and the board display pins.
//  - Owns its own scan timing, blanking, optional blink and a tear-free message-update handshake.
//  - Successor to the single-message, counter-driven segment mux.
// PARAMETERS
//  NUM_DIGITS    4      digits scanned; dig_sel width; range 2..8
//  SCAN_DIV      50000  clk cycles per digit slot; must be >= 2
//  BLANK_CYCLES  1      cycles at the start of each slot with segments off (anti-ghost); must be < SCAN_DIV
//  BLINK_FRAMES  64     complete frames per blink phase; must be >= 1
//  ACTIVE_LOW    1      1: segment and digit outputs are 0 = lit/selected
// PORTS
//  clk        in   1           single clock
//  rst_n      in   1           synchronous, active-low reset
//  msg_id     in   3           message index into the package table; 0 = blank
//  msg_valid  in   1           request to display msg_id
//  msg_ready  out  1           1 = new request accepted this cycle if msg_valid=1
//  blink_en   in   1           1 = blink the active message; sampled at frame boundary
//  seg        out  7           {g,f,e,d,c,b,a}, registered
//  dig_sel    out  NUM_DIGITS  one-hot digit enable (ACTIVE_LOW applied), registered; bit0 = leftmost
//  frame_tick out  1           1-cycle pulse when digit index wraps NUM_DIGITS-1 -> 0
// BEHAVIOUR
//  Reset (rst_n=0 at a clk edge):
//   - prescaler=0, digit idx=0, active msg=0, pending=0, blink phase=on.
//   - seg=all off, dig_sel=all inactive, msg_ready=1, frame_tick=0.
//   - Reset mid-frame or mid-handshake discards any pending message.
//  Scan timing:
//   - Prescaler counts 0..SCAN_DIV-1 and wraps; on wrap, idx <= (idx==NUM_DIGITS-1) ? 0 : idx+1.
//   - frame_tick is asserted in the cycle idx wraps to 0.
//  Outputs (one register stage after prescaler/idx):
//   - dig_sel selects idx.
//   - seg is forced off while prescaler < BLANK_CYCLES.
//   - Otherwise seg = decode(table[active][idx]).
//   - Blink-off phase: seg is off for every digit; dig_sel keeps scanning.
//   - ACTIVE_LOW inverts both seg and dig_sel; "off" means all bits 1 when ACTIVE_LOW=1.
//  Handshake:
//   - Request is accepted when msg_valid & msg_ready: pending <= msg_id, msg_ready <= 0 on the next cycle.
//   - msg_valid while msg_ready=0 is ignored; the requester holds the request.
//   - Pending is promoted to active in the frame_tick cycle. The new message first appears on digit 0; no frame mixes two messages.
//   - msg_ready returns to 1 in the cycle after promotion.
//   - Acceptance and promotion can never coincide, because ready=0 while pending.
//   - Re-requesting the active id is legal; it is promoted normally and the display shows no visible change.
//  Blink:
//   - blink_en is sampled at each frame_tick.
//   - When 1, a frame counter 0..BLINK_FRAMES-1 toggles the phase on each wrap.
//   - When 0, the counter is cleared and the phase is forced on.
//   - Promoting a new message resets the frame counter and sets phase on.
//  Widths: prescaler $clog2(SCAN_DIV), idx $clog2(NUM_DIGITS), frame counter $clog2(BLINK_FRAMES+1). All wraps are explicit compares, never overflow.
//  Table entries beyond NUM_DIGITS are ignored; missing entries display blank.
// STRUCTURE
//  seg_pkg (shared):
//   - 5-bit char codes: CH_BLANK, CH_0..CH_9, CH_C, CH_E, CH_r, CH_S, CH_A, CH_F, CH_P.
//   - MSG_TABLE[8][8] of char codes (id 0 all blank, 1 "Err ", 2 "CE0 ", 3 "SEr ", ...).
//   - SEG_OFF constant.
//  Sub-module seg_char_decode: combinational char code -> active-high {g..a}, default blank. ACTIVE_LOW inversion is done in the top level.
//  Top level holds the prescaler, idx, handshake, blink FSM (ON/OFF) and output registers.
// TESTING (NUM_DIGITS=4, SCAN_DIV=4, BLANK_CYCLES=1, BLINK_FRAMES=2, ACTIVE_LOW=1)
//  1. Hold rst_n=0 for 3 cycles.
//     -> seg=7'h7F, dig_sel=4'hF, msg_ready=1.
//     -> After release, dig_sel walks E,D,B,7 every 4 cycles.
//     -> frame_tick once per 16 cycles.
//  2. msg_id=1, msg_valid=1 for 1 cycle mid-frame.
//     -> msg_ready=0 until the frame_tick cycle, then 1.
//     -> Digits show E,r,r,blank from digit 0 of the next frame.
//     -> seg=7'h7F in the first cycle of every slot.
//  3. Second request (id=2) while msg_ready=0 -> ignored; display stays "Err".
//     Re-issued after ready returns -> "CE0 " next frame.
//  4. blink_en=1 -> segments on for 2 frames, off for 2 frames, repeating; dig_sel never stops.
//     New message accepted mid-off phase -> shown on at promotion.
//  5. Assert rst_n=0 while a request is pending and mid-slot.
//     -> Next cycle: all outputs at reset values, pending discarded, blank display.
//  6. Assertions: dig_sel always one-hot or all inactive; never two messages within one frame.

Source files
------------

// File: rtl/seg_message_scanner_pkg.sv
// Shared definitions for the multiplexed 7-segment message scanner.
// Provides the character code set, the fixed message table, the blink FSM
// state type and the segment "off" pattern (active-high, {g,f,e,d,c,b,a}).
package seg_message_scanner_pkg;

   localparam int unsigned CHAR_W    = 5;
   localparam int unsigned SEG_W     = 7;
   localparam int unsigned MSG_ID_W  = 3;
   localparam int unsigned MSG_LEN   = 8;
   localparam int unsigned MSG_COUNT = 8;

   typedef enum logic [CHAR_W-1:0] {
      CH_BLANK = 5'd0,
      CH_0, CH_1, CH_2, CH_3, CH_4, CH_5, CH_6, CH_7, CH_8, CH_9,
      CH_C, CH_E, CH_r, CH_S, CH_A, CH_F, CH_P
   } char_e;

   typedef enum logic {
      BLINK_ON  = 1'b0,
      BLINK_OFF = 1'b1
   } blink_state_e;

   localparam logic [SEG_W-1:0] SEG_OFF = 7'h00;

   // Leftmost character first; only the first NUM_DIGITS entries are shown.
   localparam char_e MSG_TABLE [MSG_COUNT][MSG_LEN] = '{
      '{CH_BLANK, CH_BLANK, CH_BLANK, CH_BLANK, CH_BLANK, CH_BLANK, CH_BLANK, CH_BLANK},
      '{CH_E,     CH_r,     CH_r,     CH_BLANK, CH_BLANK, CH_BLANK, CH_BLANK, CH_BLANK},
      '{CH_C,     CH_E,     CH_0,     CH_BLANK, CH_BLANK, CH_BLANK, CH_BLANK, CH_BLANK},
      '{CH_S,     CH_E,     CH_r,     CH_BLANK, CH_BLANK, CH_BLANK, CH_BLANK, CH_BLANK},
      '{CH_C,     CH_E,     CH_1,     CH_BLANK, CH_BLANK, CH_BLANK, CH_BLANK, CH_BLANK},
      '{CH_S,     CH_A,     CH_F,     CH_E,     CH_BLANK, CH_BLANK, CH_BLANK, CH_BLANK},
      '{CH_A,     CH_P,     CH_2,     CH_0,     CH_BLANK, CH_BLANK, CH_BLANK, CH_BLANK},
      '{CH_9,     CH_8,     CH_7,     CH_6,     CH_5,     CH_4,     CH_3,     CH_2}
   };

endpackage

// File: rtl/seg_message_scanner_if.sv
// Message request handshake between the machine controller and the scanner.
//   msg_id    : message index into MSG_TABLE (0 = blank)
//   msg_valid : request to display msg_id, held by the requester until accepted
//   msg_ready : scanner can accept a new request this cycle
//   blink_en  : blink the active message (sampled at frame boundaries)
interface seg_message_scanner_if;
   import seg_message_scanner_pkg::*;

   logic [MSG_ID_W-1:0] msg_id;
   logic                msg_valid;
   logic                msg_ready;
   logic                blink_en;

   modport master (output msg_id, output msg_valid, output blink_en, input msg_ready);
   modport slave  (input msg_id, input msg_valid, input blink_en, output msg_ready);
endinterface

// File: rtl/seg_message_scanner_char_decode.sv
// Combinational character code to active-high segment pattern.
//   char_i  : character code
//   seg_c_o : {g,f,e,d,c,b,a}, 1 = lit; unknown codes decode to blank
module seg_char_decode
   import seg_message_scanner_pkg::*;
(
   input  char_e              char_i,
   output logic [SEG_W-1:0]   seg_c_o
);

   always_comb begin
      seg_c_o = SEG_OFF;
      case (char_i)
         CH_0:    seg_c_o = 7'h3F;
         CH_1:    seg_c_o = 7'h06;
         CH_2:    seg_c_o = 7'h5B;
         CH_3:    seg_c_o = 7'h4F;
         CH_4:    seg_c_o = 7'h66;
         CH_5:    seg_c_o = 7'h6D;
         CH_6:    seg_c_o = 7'h7D;
         CH_7:    seg_c_o = 7'h07;
         CH_8:    seg_c_o = 7'h7F;
         CH_9:    seg_c_o = 7'h6F;
         CH_C:    seg_c_o = 7'h39;
         CH_E:    seg_c_o = 7'h79;
         CH_r:    seg_c_o = 7'h50;
         CH_S:    seg_c_o = 7'h6D;
         CH_A:    seg_c_o = 7'h77;
         CH_F:    seg_c_o = 7'h71;
         CH_P:    seg_c_o = 7'h73;
         default: seg_c_o = SEG_OFF;
      endcase
   end

endmodule

// File: rtl/seg_message_scanner.sv
// Multiplexed 7-segment scanner for fixed status/error messages.
//   clk, rst_n   : clock, synchronous active-low reset
//   msg_if       : request handshake (slave side) and blink enable
//   seg_o        : {g,f,e,d,c,b,a}, registered, polarity per ACTIVE_LOW
//   dig_sel_o    : one-hot digit enable, bit0 = leftmost, registered
//   frame_tick_o : 1-cycle pulse in the cycle the digit index wraps to 0
module seg_message_scanner
   import seg_message_scanner_pkg::*;
#(
   parameter int unsigned NUM_DIGITS   = 4,
   parameter int unsigned SCAN_DIV     = 50000,
   parameter int unsigned BLANK_CYCLES = 1,
   parameter int unsigned BLINK_FRAMES = 64,
   parameter int unsigned ACTIVE_LOW   = 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   seg_message_scanner_if.slave    msg_if,
   output logic [SEG_W-1:0]        seg_o,
   output logic [NUM_DIGITS-1:0]   dig_sel_o,
   output logic                    frame_tick_o
);

   localparam int unsigned PSC_W = $clog2(SCAN_DIV);
   localparam int unsigned IDX_W = $clog2(NUM_DIGITS);
   localparam int unsigned FC_W  = $clog2(BLINK_FRAMES + 1);

   localparam logic [SEG_W-1:0]      SEG_IDLE = (ACTIVE_LOW != 0) ? ~SEG_OFF : SEG_OFF;
   localparam logic [NUM_DIGITS-1:0] DIG_IDLE = (ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}}
                                                                  : {NUM_DIGITS{1'b0}};

   logic [PSC_W-1:0]      psc_q, psc_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [MSG_ID_W-1:0]   active_q, active_d;
   logic [MSG_ID_W-1:0]   pend_q, pend_d;
   logic                  ready_q, ready_d;
   logic                  promo_q, promo_d;
   logic [FC_W-1:0]       fc_q, fc_d;
   blink_state_e          blink_q, blink_d;
   logic [SEG_W-1:0]      seg_q, seg_d;
   logic [NUM_DIGITS-1:0] dig_q, dig_d;
   logic                  tick_q, tick_d;

   logic                  psc_wrap_c;
   logic                  frame_wrap_c;
   char_e                 cur_char_c;
   logic [SEG_W-1:0]      seg_raw_c;
   logic [SEG_W-1:0]      seg_hi_c;
   logic [NUM_DIGITS-1:0] dig_hi_c;

   assign cur_char_c = MSG_TABLE[active_q][3'(idx_q)];

   seg_char_decode u_dec (
      .char_i  (cur_char_c),
      .seg_c_o (seg_raw_c)
   );

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         psc_q    <= '0;
         idx_q    <= '0;
         active_q <= '0;
         pend_q   <= '0;
         ready_q  <= 1'b1;
         promo_q  <= 1'b0;
         fc_q     <= '0;
         blink_q  <= BLINK_ON;
         seg_q    <= SEG_IDLE;
         dig_q    <= DIG_IDLE;
         tick_q   <= 1'b0;
      end else begin
         psc_q    <= psc_d;
         idx_q    <= idx_d;
         active_q <= active_d;
         pend_q   <= pend_d;
         ready_q  <= ready_d;
         promo_q  <= promo_d;
         fc_q     <= fc_d;
         blink_q  <= blink_d;
         seg_q    <= seg_d;
         dig_q    <= dig_d;
         tick_q   <= tick_d;
      end
   end

   // Scan timing, handshake, blink FSM and output stage
   always_comb begin
      psc_d    = psc_q;
      idx_d    = idx_q;
      active_d = active_q;
      pend_d   = pend_q;
      ready_d  = ready_q;
      promo_d  = 1'b0;
      fc_d     = fc_q;
      blink_d  = blink_q;
      seg_hi_c = SEG_OFF;
      dig_hi_c = '0;

      psc_wrap_c   = (psc_q == PSC_W'(SCAN_DIV - 1));
      frame_wrap_c = psc_wrap_c && (idx_q == IDX_W'(NUM_DIGITS - 1));

      psc_d = psc_wrap_c ? '0 : psc_q + PSC_W'(1);
      if (psc_wrap_c) begin
         idx_d = frame_wrap_c ? '0 : idx_q + IDX_W'(1);
      end

      // ready_q=0 exactly while a request is pending, so accept and promote are exclusive
      if (msg_if.msg_valid && ready_q) begin
         pend_d  = msg_if.msg_id;
         ready_d = 1'b0;
      end
      if (frame_wrap_c && !ready_q) begin
         active_d = pend_q;
         promo_d  = 1'b1;
      end
      if (promo_q) begin
         ready_d = 1'b1;
      end

      // Phase changes only at frame boundaries so a frame is never split
      if (frame_wrap_c) begin
         if (!ready_q || !msg_if.blink_en) begin
            fc_d    = '0;
            blink_d = BLINK_ON;
         end else if (fc_q == FC_W'(BLINK_FRAMES - 1)) begin
            fc_d    = '0;
            blink_d = (blink_q == BLINK_ON) ? BLINK_OFF : BLINK_ON;
         end else begin
            fc_d = fc_q + FC_W'(1);
         end
      end

      if ((psc_q >= PSC_W'(BLANK_CYCLES)) && (blink_q == BLINK_ON)) begin
         seg_hi_c = seg_raw_c;
      end
      dig_hi_c = NUM_DIGITS'(1) << idx_q;

      seg_d  = (ACTIVE_LOW != 0) ? ~seg_hi_c : seg_hi_c;
      dig_d  = (ACTIVE_LOW != 0) ? ~dig_hi_c : dig_hi_c;
      tick_d = frame_wrap_c;
   end

   assign msg_if.msg_ready = ready_q;
   assign seg_o            = seg_q;
   assign dig_sel_o        = dig_q;
   assign frame_tick_o     = tick_q;

endmodule

// File: tb/tb_seg_message_scanner.sv
// Randomized self-checking bench for seg_message_scanner against a
// frame/slot level reference model built from message text and a glyph table.
module tb_seg_message_scanner;
   import seg_message_scanner_pkg::*;

   localparam int ND    = 4;
   localparam int SD    = 4;
   localparam int BC    = 1;
   localparam int BF    = 2;
   localparam int FRAME = ND * SD;

   logic          clk;
   logic          rst_n;
   logic [6:0]    seg_o;
   logic [ND-1:0] dig_sel_o;
   logic          frame_tick_o;

   seg_message_scanner_if mif ();

   seg_message_scanner #(
      .NUM_DIGITS   (ND),
      .SCAN_DIV     (SD),
      .BLANK_CYCLES (BC),
      .BLINK_FRAMES (BF),
      .ACTIVE_LOW   (1)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .msg_if       (mif),
      .seg_o        (seg_o),
      .dig_sel_o    (dig_sel_o),
      .frame_tick_o (frame_tick_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Reference model state
   int         t;
   bit         m_ready;
   int         m_pend;
   int         m_active;
   int         m_ready_at;
   bit         m_on;
   int         m_frames;
   logic [6:0] exp_seg;
   logic [ND-1:0] exp_dig;
   logic       exp_tick;
   logic       exp_ready;

   function automatic logic [63:0] msg_text(input int id);
      case (id)
         0: return "        ";
         1: return "Err     ";
         2: return "CE0     ";
         3: return "SEr     ";
         4: return "CE1     ";
         5: return "SAFE    ";
         6: return "AP20    ";
         default: return "98765432";
      endcase
   endfunction

   function automatic logic [6:0] glyph(input logic [7:0] ch);
      case (ch)
         "0": return 7'h3F;  "1": return 7'h06;  "2": return 7'h5B;
         "3": return 7'h4F;  "4": return 7'h66;  "5": return 7'h6D;
         "6": return 7'h7D;  "7": return 7'h07;  "8": return 7'h7F;
         "9": return 7'h6F;  "C": return 7'h39;  "E": return 7'h79;
         "r": return 7'h50;  "S": return 7'h6D;  "A": return 7'h77;
         "F": return 7'h71;  "P": return 7'h73;
         default: return 7'h00;
      endcase
   endfunction

   function automatic logic [7:0] msg_char(input int id, input int pos);
      logic [63:0] s;
      s = msg_text(id);
      return s[63 - 8*pos -: 8];
   endfunction

   task automatic model_reset();
      t          = 0;
      m_ready    = 1'b1;
      m_pend     = 0;
      m_active   = 0;
      m_ready_at = -1;
      m_on       = 1'b1;
      m_frames   = 0;
   endtask

   // Drive one cycle of inputs, predict the outputs after the next edge, advance.
   task automatic step(input bit v, input int id, input bit bl);
      int  slot, pos;
      bit  nf, promoted;
      @(negedge clk);
      rst_n         = 1'b1;
      mif.msg_valid = v;
      mif.msg_id    = 3'(id);
      mif.blink_en  = bl;
      slot     = (t / SD) % ND;
      pos      = t % SD;
      exp_dig  = ~(ND'(1) << slot);
      exp_seg  = (pos < BC || !m_on) ? 7'h7F : ~glyph(msg_char(m_active, slot));
      nf       = ((t + 1) % FRAME) == 0;
      exp_tick = nf;
      promoted = 1'b0;
      if (m_ready) begin
         if (v) begin
            m_pend  = id;
            m_ready = 1'b0;
         end
      end else if (m_ready_at == t + 1) begin
         m_ready = 1'b1;
      end else if (nf) begin
         m_active   = m_pend;
         m_ready_at = t + 2;
         m_on       = 1'b1;
         m_frames   = 0;
         promoted   = 1'b1;
      end
      if (nf && !promoted) begin
         if (!bl) begin
            m_on     = 1'b1;
            m_frames = 0;
         end else begin
            m_frames++;
            if (m_frames == BF) begin
               m_frames = 0;
               m_on     = !m_on;
            end
         end
      end
      exp_ready = m_ready;
      @(posedge clk);
      t++;
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; mif.msg_valid = 1'b0; mif.msg_id = '0; mif.blink_en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         checks += 4;
         if (seg_o !== 7'h7F) begin errors++; $display("FAIL reset_seg got %h exp 7f", seg_o); end
         if (dig_sel_o !== 4'hF) begin errors++; $display("FAIL reset_dig got %h exp f", dig_sel_o); end
         if (mif.msg_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", mif.msg_ready); end
         if (frame_tick_o !== 1'b0) begin errors++; $display("FAIL reset_tick got %b exp 0", frame_tick_o); end
      end
      model_reset();
   endtask

   task automatic test_scan();
      int ticks = 0;
      for (int i = 0; i < 3 * FRAME; i++) begin
         step(0, 0, 0);
         checks += 3;
         if (dig_sel_o !== exp_dig) begin errors++; $display("FAIL scan_dig t=%0d got %h exp %h", t, dig_sel_o, exp_dig); end
         if (seg_o !== exp_seg) begin errors++; $display("FAIL scan_seg t=%0d got %h exp %h", t, seg_o, exp_seg); end
         if (frame_tick_o !== exp_tick) begin errors++; $display("FAIL scan_tick t=%0d got %b exp %b", t, frame_tick_o, exp_tick); end
         if (frame_tick_o === 1'b1) ticks++;
      end
      checks++;
      if (ticks != 3) begin errors++; $display("FAIL scan_tick_count got %0d exp 3", ticks); end
   endtask

   task automatic test_message();
      int pre = int'($urandom_range(2, 10));
      for (int i = 0; i < pre + 40; i++) begin
         step(i == pre, 1, 0);
         checks += 4;
         if (dig_sel_o !== exp_dig) begin errors++; $display("FAIL msg_dig t=%0d got %h exp %h", t, dig_sel_o, exp_dig); end
         if (seg_o !== exp_seg) begin errors++; $display("FAIL msg_seg t=%0d got %h exp %h", t, seg_o, exp_seg); end
         if (frame_tick_o !== exp_tick) begin errors++; $display("FAIL msg_tick t=%0d got %b exp %b", t, frame_tick_o, exp_tick); end
         if (mif.msg_ready !== exp_ready) begin errors++; $display("FAIL msg_ready t=%0d got %b exp %b", t, mif.msg_ready, exp_ready); end
      end
   endtask

   task automatic test_back_to_back();
      int phase = 0;
      int i     = 0;
      step(1, 3, 0);
      // phase 0: hold id 2 while busy; 1: idle until ready; 2: reissue id 2; 3: settle
      while (phase < 4 && i < 200) begin
         case (phase)
            0: begin step(1, 2, 0); if (i >= 5) begin phase = 1; end end
            1: begin step(0, 0, 0); if (m_ready) begin phase = 2; end end
            2: begin step(1, 2, 0); phase = 3; end
            default: begin step(0, 0, 0); if (i > 60) begin phase = 4; end end
         endcase
         i++;
         checks += 3;
         if (seg_o !== exp_seg) begin errors++; $display("FAIL b2b_seg t=%0d got %h exp %h", t, seg_o, exp_seg); end
         if (mif.msg_ready !== exp_ready) begin errors++; $display("FAIL b2b_ready t=%0d got %b exp %b", t, mif.msg_ready, exp_ready); end
         if (dig_sel_o !== exp_dig) begin errors++; $display("FAIL b2b_dig t=%0d got %h exp %h", t, dig_sel_o, exp_dig); end
      end
      checks++;
      if (phase != 4) begin errors++; $display("FAIL b2b_timeout got phase %0d exp 4", phase); end
   endtask

   task automatic test_blink();
      bit sent = 1'b0;
      for (int i = 0; i < 8 * FRAME; i++) begin
         if (!sent && !m_on && m_ready && (t % FRAME) == 6) begin
            step(1, int'($urandom_range(1, 7)), 1);
            sent = 1'b1;
         end else begin
            step(0, 0, 1);
         end
         checks += 4;
         if (seg_o !== exp_seg) begin errors++; $display("FAIL blink_seg t=%0d got %h exp %h", t, seg_o, exp_seg); end
         if (dig_sel_o !== exp_dig) begin errors++; $display("FAIL blink_dig t=%0d got %h exp %h", t, dig_sel_o, exp_dig); end
         if (mif.msg_ready !== exp_ready) begin errors++; $display("FAIL blink_ready t=%0d got %b exp %b", t, mif.msg_ready, exp_ready); end
         if ($countones(~dig_sel_o) != 1) begin errors++; $display("FAIL blink_onehot t=%0d got %h exp one-hot", t, dig_sel_o); end
      end
      checks++;
      if (!sent) begin errors++; $display("FAIL blink_offphase_request got none exp 1 sent"); end
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 40 && !m_ready; i++) step(0, 0, 0);
      step(1, 5, 0);
      for (int i = 0; i < int'($urandom_range(1, 6)); i++) step(0, 0, 0);
      @(negedge clk);
      rst_n = 1'b0; mif.msg_valid = 1'b0;
      @(posedge clk); #1;
      checks += 4;
      if (seg_o !== 7'h7F) begin errors++; $display("FAIL rmid_seg got %h exp 7f", seg_o); end
      if (dig_sel_o !== 4'hF) begin errors++; $display("FAIL rmid_dig got %h exp f", dig_sel_o); end
      if (mif.msg_ready !== 1'b1) begin errors++; $display("FAIL rmid_ready got %b exp 1", mif.msg_ready); end
      if (frame_tick_o !== 1'b0) begin errors++; $display("FAIL rmid_tick got %b exp 0", frame_tick_o); end
      model_reset();
      for (int i = 0; i < 3 * FRAME; i++) begin
         step(0, 0, 0);
         checks += 3;
         if (seg_o !== exp_seg) begin errors++; $display("FAIL rmid_after_seg t=%0d got %h exp %h", t, seg_o, exp_seg); end
         if (dig_sel_o !== exp_dig) begin errors++; $display("FAIL rmid_after_dig t=%0d got %h exp %h", t, dig_sel_o, exp_dig); end
         if (mif.msg_ready !== exp_ready) begin errors++; $display("FAIL rmid_after_ready t=%0d got %b exp %b", t, mif.msg_ready, exp_ready); end
      end
   endtask

   task automatic test_random();
      bit bl = 1'b0;
      for (int i = 0; i < 700; i++) begin
         if ($urandom_range(0, 40) == 0) bl = !bl;
         step($urandom_range(0, 5) == 0, int'($urandom_range(0, 7)), bl);
         checks += 5;
         if (seg_o !== exp_seg) begin errors++; $display("FAIL rand_seg t=%0d got %h exp %h", t, seg_o, exp_seg); end
         if (dig_sel_o !== exp_dig) begin errors++; $display("FAIL rand_dig t=%0d got %h exp %h", t, dig_sel_o, exp_dig); end
         if (frame_tick_o !== exp_tick) begin errors++; $display("FAIL rand_tick t=%0d got %b exp %b", t, frame_tick_o, exp_tick); end
         if (mif.msg_ready !== exp_ready) begin errors++; $display("FAIL rand_ready t=%0d got %b exp %b", t, mif.msg_ready, exp_ready); end
         if ($countones(~dig_sel_o) != 1) begin errors++; $display("FAIL rand_onehot t=%0d got %h exp one-hot", t, dig_sel_o); end
      end
   endtask

   initial begin
      test_reset();
      test_scan();
      test_message();
      test_back_to_back();
      test_blink();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
